// File: rtl/dp_responder_pkg.sv
// Shared widths, opcodes, instruction field positions and state encoding
// for the datapath instruction responder.
package dp_responder_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH    = 16;
    localparam int X_COORD_WIDTH     = 8;
    localparam int Y_COORD_WIDTH     = 7;
    localparam int COLOUR_WIDTH      = 3;
    localparam int OP_WIDTH          = 4;
    localparam int LAT_CNT_WIDTH     = 3;

    localparam logic [OP_WIDTH-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_PLOT  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_READ  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_WRITE = 4'd3;

    localparam int INSTR_OP_MSB     = 31;
    localparam int INSTR_OP_LSB     = 28;
    localparam int INSTR_ADDR_MSB   = 15;
    localparam int INSTR_ADDR_LSB   = 0;
    localparam int INSTR_WDATA_MSB  = 27;
    localparam int INSTR_WDATA_LSB  = 16;
    localparam int INSTR_PLOT_BIT   = 18;
    localparam int INSTR_COLOUR_MSB = 17;
    localparam int INSTR_COLOUR_LSB = 15;
    localparam int INSTR_Y_MSB      = 14;
    localparam int INSTR_Y_LSB      = 8;
    localparam int INSTR_X_MSB      = 7;
    localparam int INSTR_X_LSB      = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]       op;
        logic                      illegal;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [RESULT_WIDTH-1:0]   wdata;
        logic [X_COORD_WIDTH-1:0]  x;
        logic [Y_COORD_WIDTH-1:0]  y;
        logic [COLOUR_WIDTH-1:0]   colour;
        logic                      plot;
    } decoded_t;

endpackage

// File: rtl/dp_responder_decode.sv
// Combinational field extractor for the 32-bit responder instruction word.
module dp_decode
    import dp_responder_pkg::*;
(
    input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
    output decoded_t                     o_dec
);

    logic [OP_WIDTH-1:0] w_op;

    assign w_op = i_instruction[INSTR_OP_MSB:INSTR_OP_LSB];

    always_comb begin
        o_dec         = '0;
        o_dec.op      = w_op;
        o_dec.illegal = (w_op > OP_WRITE);
        o_dec.addr    = i_instruction[INSTR_ADDR_MSB:INSTR_ADDR_LSB];
        // write data is 12 bits in the word, zero-extended to the RAM width
        o_dec.wdata   = {{(RESULT_WIDTH-(INSTR_WDATA_MSB-INSTR_WDATA_LSB+1)){1'b0}},
                         i_instruction[INSTR_WDATA_MSB:INSTR_WDATA_LSB]};
        o_dec.x       = i_instruction[INSTR_X_MSB:INSTR_X_LSB];
        o_dec.y       = i_instruction[INSTR_Y_MSB:INSTR_Y_LSB];
        o_dec.colour  = i_instruction[INSTR_COLOUR_MSB:INSTR_COLOUR_LSB];
        o_dec.plot    = i_instruction[INSTR_PLOT_BIT];
    end

endmodule

// File: rtl/dp_responder.sv
// Responder end of the start/finished instruction handshake: decodes one command,
// drives the shared RAM or VGA adapter, then reports completion plus result.
module dp_responder
    import dp_responder_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         finished,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic                         error,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
    output logic [RESULT_WIDTH-1:0]      mem_data,
    output logic                         mem_wren,
    input  logic [RESULT_WIDTH-1:0]      mem_q,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(MEM_LATENCY - 1);

    state_t                         r_state;
    logic                           r_start_q;
    logic [INSTRUCTION_WIDTH-1:0]   r_instr;
    logic [LAT_CNT_WIDTH-1:0]       r_cnt;
    logic [RESULT_WIDTH-1:0]        r_pending;
    decoded_t                       w_dec;
    logic                           w_accept;

    dp_decode u_decode (
        .i_instruction (r_instr),
        .o_dec         (w_dec)
    );

    assign w_accept = (r_state == ST_IDLE) && start && !r_start_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_instr     <= '0;
            r_cnt       <= '0;
            r_pending   <= '0;
            finished    <= 1'b1;
            result      <= '0;
            error       <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            r_start_q <= start;
            mem_wren  <= 1'b0;
            vga_plot  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_instr  <= instruction;
                        finished <= 1'b0;
                        error    <= 1'b0;
                        r_state  <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (w_dec.illegal) begin
                        result   <= '0;
                        error    <= 1'b1;
                        finished <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        case (w_dec.op)
                            OP_PLOT: begin
                                vga_x      <= w_dec.x;
                                vga_y      <= w_dec.y;
                                vga_colour <= w_dec.colour;
                                vga_plot   <= w_dec.plot;
                                r_pending  <= '0;
                                r_cnt      <= '0;
                                r_state    <= ST_READ_WAIT;
                            end
                            OP_READ: begin
                                mem_address <= w_dec.addr;
                                r_cnt       <= LAT_LOAD;
                                r_state     <= ST_READ_WAIT;
                            end
                            OP_WRITE: begin
                                mem_address <= w_dec.addr;
                                mem_data    <= w_dec.wdata;
                                mem_wren    <= 1'b1;
                                r_pending   <= w_dec.wdata;
                                r_cnt       <= '0;
                                r_state     <= ST_READ_WAIT;
                            end
                            default: begin
                                finished <= 1'b1;
                                r_state  <= ST_DONE;
                            end
                        endcase
                    end
                end

                // PLOT and WRITE also pass through here with a zero count, giving
                // them their one-cycle completion delay without a separate state.
                ST_READ_WAIT: begin
                    if (r_cnt == '0) begin
                        result   <= (w_dec.op == OP_READ) ? mem_q : r_pending;
                        finished <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_responder.sv
// Self-checking bench: table of commands with a scoreboard, plus hand-written
// sequences for held start, start edge during DONE and reset mid-command.
module tb_dp_responder;
    import dp_responder_pkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instruction;
    logic        finished;
    logic [15:0] result;
    logic        error;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dp_responder #(.MEM_LATENCY(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .finished    (finished),
        .result      (result),
        .error       (error),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    // RAM model: address register lives in the responder, one q register here (LAT=2)
    logic [15:0] ram [0:65535];
    logic [15:0] q_stage;
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_en)
            ram[pre_addr] <= pre_data;
        else if (mem_wren)
            ram[mem_address] <= mem_data;
        q_stage <= ram[mem_address];
    end
    assign mem_q = q_stage;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          lat;
        logic [15:0] res;
        logic        err;
        int          plots;
        int          wrens;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  col;
        logic        chk_addr;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs[14];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string name, input logic [31:0] instr, input int lat,
                                 input logic [15:0] res, input logic err, input int plots,
                                 input int wrens, input logic [7:0] x, input logic [6:0] y,
                                 input logic [2:0] col, input logic chk_addr,
                                 input logic [15:0] addr);
        vec_t v;
        v.name = name; v.instr = instr; v.lat = lat; v.res = res; v.err = err;
        v.plots = plots; v.wrens = wrens; v.x = x; v.y = y; v.col = col;
        v.chk_addr = chk_addr; v.addr = addr;
        return v;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        vec_t        e;
        int          lat = 99;
        int          nplot = 0;
        int          nwren = 0;
        logic [7:0]  px = '0;
        logic [6:0]  py = '0;
        logic [2:0]  pc = '0;
        @(negedge clock);
        start = 1'b1;
        instruction = v.instr;
        sb.push_back(v);
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        e = sb.pop_front();
        chk({e.name, "_busy"}, {31'd0, finished}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (vga_plot) begin nplot++; px = vga_x; py = vga_y; pc = vga_colour; end
            if (mem_wren) nwren++;
            if (finished) begin lat = k; break; end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (vga_plot) nplot++;
            if (mem_wren) nwren++;
        end
        chk({e.name, "_latency"}, lat, e.lat);
        chk({e.name, "_finished_held"}, {31'd0, finished}, 32'd1);
        chk({e.name, "_result"}, {16'd0, result}, {16'd0, e.res});
        chk({e.name, "_error"}, {31'd0, error}, {31'd0, e.err});
        chk({e.name, "_plots"}, nplot, e.plots);
        chk({e.name, "_wrens"}, nwren, e.wrens);
        if (e.plots > 0) begin
            chk({e.name, "_x"}, {24'd0, px}, {24'd0, e.x});
            chk({e.name, "_y"}, {25'd0, py}, {25'd0, e.y});
            chk({e.name, "_colour"}, {29'd0, pc}, {29'd0, e.col});
        end
        if (e.chk_addr)
            chk({e.name, "_addr"}, {16'd0, mem_address}, {16'd0, e.addr});
        $display("txn %-8s instr=0x%08h lat=%0d result=0x%04h error=%0d plots=%0d wrens=%0d",
                 e.name, e.instr, lat, result, error, nplot, nwren);
    endtask

    // Drives a command, then asserts reset between edges once it is under way.
    task automatic reset_mid(input string name, input logic [31:0] instr);
        int pulses = 0;
        int falls = 0;
        @(negedge clock);
        start = 1'b1;
        instruction = instr;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk({name, "_rst_finished"}, {31'd0, finished}, 32'd1);
        chk({name, "_rst_result"}, {16'd0, result}, 32'd0);
        chk({name, "_rst_error"}, {31'd0, error}, 32'd0);
        chk({name, "_rst_wren"}, {31'd0, mem_wren}, 32'd0);
        chk({name, "_rst_plot"}, {31'd0, vga_plot}, 32'd0);
        chk({name, "_rst_addr"}, {16'd0, mem_address}, 32'd0);
        #3 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (mem_wren || vga_plot) pulses++;
            if (!finished) falls++;
        end
        chk({name, "_post_pulses"}, pulses, 0);
        chk({name, "_post_busy"}, falls, 0);
        $display("txn reset-mid %s instr=0x%08h pulses=%0d busy_cycles=%0d", name, instr, pulses, falls);
    endtask

    task automatic count_accepts(input int cycles, output int n);
        logic prev;
        n = 0;
        prev = finished;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (prev && !finished) n++;
            prev = finished;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        instruction = '0;

        #1;
        chk("reset_finished", {31'd0, finished}, 32'd1);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        chk("reset_pulses", {30'd0, mem_wren, vga_plot}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        preload(16'h0040, 16'h0055);
        preload(16'h0060, 16'h1234);

        vecs[0]  = mkv("nop0",   32'h0000_0000, 1,     16'h0000, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);
        vecs[1]  = mkv("plot1",  32'h1004_2D1F, 2,     16'h0000, 1'b0, 1, 0, 8'h1F, 7'h2D, 3'd0, 1'b0, 16'h0);
        vecs[2]  = mkv("plot0",  32'h1003_8A05, 2,     16'h0000, 1'b0, 0, 0, 8'h05, 7'h0A, 3'd7, 1'b0, 16'h0);
        vecs[3]  = mkv("plotmax",32'h1007_FFFF, 2,     16'h0000, 1'b0, 1, 0, 8'hFF, 7'h7F, 3'd7, 1'b0, 16'h0);
        vecs[4]  = mkv("wr41",   32'h3ABC_0041, 2,     16'h0ABC, 1'b0, 0, 1, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0041);
        vecs[5]  = mkv("rd41",   32'h2000_0041, 1+LAT, 16'h0ABC, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0041);
        vecs[6]  = mkv("rd40",   32'h2000_0040, 1+LAT, 16'h0055, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0040);
        vecs[7]  = mkv("nop1",   32'h0000_0000, 1,     16'h0055, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);
        vecs[8]  = mkv("ill7",   32'h7000_0000, 1,     16'h0000, 1'b1, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);
        vecs[9]  = mkv("nop2",   32'h0000_0000, 1,     16'h0000, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);
        vecs[10] = mkv("wrffff", 32'h3FFF_FFFF, 2,     16'h0FFF, 1'b0, 0, 1, 8'h00, 7'h00, 3'd0, 1'b1, 16'hFFFF);
        vecs[11] = mkv("rdffff", 32'h2000_FFFF, 1+LAT, 16'h0FFF, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b1, 16'hFFFF);
        vecs[12] = mkv("illF",   32'hF123_4567, 1,     16'h0000, 1'b1, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);
        vecs[13] = mkv("nop3",   32'h0000_0000, 1,     16'h0000, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b0, 16'h0);

        for (int i = 0; i < 14; i++)
            run_cmd(vecs[i]);

        // start held high: one accept only, then a re-toggle is accepted again
        @(negedge clock);
        start = 1'b1;
        instruction = 32'h0000_0000;
        count_accepts(20, n);
        chk("held_start_accepts", n, 1);
        $display("txn held-start accepts=%0d", n);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        count_accepts(4, n);
        chk("retoggle_accepts", n, 1);
        $display("txn re-toggle accepts=%0d", n);
        start = 1'b0;
        repeat (3) @(negedge clock);

        // rising start edge landing on the DONE cycle is dropped
        @(negedge clock);
        start = 1'b1;
        instruction = 32'h0000_0000;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 start = 1'b1;
        count_accepts(6, n);
        chk("done_edge_accepts", n, 0);
        $display("txn start-edge-in-DONE accepts=%0d", n);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        count_accepts(4, n);
        chk("after_done_retoggle", n, 1);
        $display("txn re-toggle after DONE accepts=%0d", n);
        start = 1'b0;
        repeat (3) @(negedge clock);

        // give result a nonzero value so the reset clear is visible
        run_cmd(mkv("wr50", 32'h3123_0050, 2, 16'h0123, 1'b0, 0, 1, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0050));
        reset_mid("read", 32'h2000_0040);
        run_cmd(mkv("wr51", 32'h3456_0051, 2, 16'h0456, 1'b0, 0, 1, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0051));
        reset_mid("write", 32'h3777_0060);
        reset_mid("plot", 32'h1004_2D1F);
        run_cmd(mkv("rd60", 32'h2000_0060, 1+LAT, 16'h1234, 1'b0, 0, 0, 8'h00, 7'h00, 3'd0, 1'b1, 16'h0060));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
